// File: rtl/abs_diff_sad_pipe_if.sv
// Stream-in / result-out bundle for abs_diff_sad_pipe.
// out_err_bound exists only when ABS_DIFF_ERR_BOUND_EN is defined.
interface abs_diff_sad_pipe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 26,
  parameter int CNT_W = 16,
  parameter int ET_W  = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_last;
  logic [ET_W-1:0]        et;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_sad;
  logic [CNT_W-1:0]       out_beats;
  logic                   out_sat;

`ifdef ABS_DIFF_ERR_BOUND_EN
  logic [ACC_W-1:0]       out_err_bound;

  modport slave (
    input  in_valid, in_a, in_b, in_last, et, out_ready,
    output in_ready, out_valid, out_sad, out_beats, out_sat, out_err_bound
  );
  modport master (
    output in_valid, in_a, in_b, in_last, et, out_ready,
    input  in_ready, out_valid, out_sad, out_beats, out_sat, out_err_bound
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_last, et, out_ready,
    output in_ready, out_valid, out_sad, out_beats, out_sat
  );
  modport master (
    output in_valid, in_a, in_b, in_last, et, out_ready,
    input  in_ready, out_valid, out_sad, out_beats, out_sat
  );
`endif
endinterface

// File: rtl/abs_diff_sad_pipe.sv
// Pipelined multi-lane sum-of-absolute-differences engine with LSB truncation (et).
// Define ABS_DIFF_ERR_BOUND_EN to add the out_err_bound worst-case error output.
module abs_diff_sad_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 26,
  parameter int CNT_W = 16,
  parameter int ET_W  = 3
) (
  input logic                clk,
  input logic                rst,
  abs_diff_sad_pipe_if.slave bus
);
  localparam int SUM_W   = WIDTH + $clog2(LANES);
  localparam int EXT_W   = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int PRD_RAW = CNT_W + WIDTH + $clog2(LANES) + 1;
  localparam int PRD_W   = (PRD_RAW > ACC_W) ? PRD_RAW : ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             accept;
  logic             load_out;
  logic             clear_frame;
  logic             first_reg;
  logic [ET_W-1:0]  et_lat_reg;
  logic [ET_W-1:0]  et_sel;
  logic [ET_W-1:0]  et_eff;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] lane_d [LANES];
  logic [SUM_W-1:0] beat_sum;

  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic [SUM_W-1:0] s1_sum_reg;
  logic             s2_done_reg;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] beats_reg;
  logic             sat_reg;
  logic [EXT_W-1:0] acc_ext;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] beats_next;

  logic [ACC_W-1:0] out_sad_reg;
  logic [CNT_W-1:0] out_beats_reg;
  logic             out_sat_reg;

  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.in_ready   = (state_reg == ACCUM);
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.out_sad    = out_sad_reg;
  assign bus.out_beats  = out_beats_reg;
  assign bus.out_sat    = out_sat_reg;
  assign load_out       = (state_reg == FLUSH) && s2_done_reg;
  assign clear_frame    = (state_reg == DONE) && bus.out_ready;

  // The first beat of a frame uses the live et; later beats reuse the latched copy.
  assign et_sel    = first_reg ? bus.et : et_lat_reg;
  assign et_eff    = (32'(et_sel) > 32'(WIDTH - 1)) ? ET_W'(WIDTH - 1) : et_sel;
  assign lane_mask = {WIDTH{1'b1}} << et_eff;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] a_lane;
    logic [WIDTH-1:0] b_lane;
    assign a_lane     = bus.in_a[gi*WIDTH +: WIDTH];
    assign b_lane     = bus.in_b[gi*WIDTH +: WIDTH];
    assign lane_d[gi] = ((a_lane >= b_lane) ? (a_lane - b_lane) : (b_lane - a_lane)) & lane_mask;
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_W'(lane_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // FLUSH waits for s2_done so the result registers see the fully updated accumulator.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && bus.in_last) state_next = FLUSH;
      FLUSH:   if (s2_done_reg)           state_next = DONE;
      DONE:    if (bus.out_ready)         state_next = ACCUM;
      default:                            state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_sum_reg   <= '0;
      s2_done_reg  <= 1'b0;
      first_reg    <= 1'b1;
      et_lat_reg   <= '0;
    end else begin
      s1_valid_reg <= accept;
      s2_done_reg  <= s1_valid_reg & s1_last_reg;
      if (accept) begin
        s1_sum_reg  <= beat_sum;
        s1_last_reg <= bus.in_last;
      end
      if (accept && first_reg) begin
        first_reg  <= 1'b0;
        et_lat_reg <= et_eff;
      end else if (clear_frame) begin
        first_reg <= 1'b1;
      end
    end
  end

  assign acc_ext    = EXT_W'(acc_reg) + EXT_W'(s1_sum_reg);
  assign acc_ovf    = (acc_ext > EXT_W'(ACC_MAX));
  assign acc_next   = acc_ovf ? ACC_MAX : acc_ext[ACC_W-1:0];
  assign beats_next = (beats_reg == CNT_MAX) ? beats_reg : beats_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      beats_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (clear_frame) begin
      acc_reg   <= '0;
      beats_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (s1_valid_reg) begin
      acc_reg   <= acc_next;
      beats_reg <= beats_next;
      sat_reg   <= sat_reg | acc_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sad_reg   <= '0;
      out_beats_reg <= '0;
      out_sat_reg   <= 1'b0;
    end else if (load_out) begin
      out_sad_reg   <= acc_reg;
      out_beats_reg <= beats_reg;
      out_sat_reg   <= sat_reg;
    end
  end

`ifdef ABS_DIFF_ERR_BOUND_EN
  logic [WIDTH-1:0] err_unit;
  logic [PRD_W-1:0] err_prod;
  logic [ACC_W-1:0] err_next;
  logic [ACC_W-1:0] err_reg;
  logic [ACC_W-1:0] out_err_reg;

  // Worst case per lane per beat is all truncated LSBs set: (1<<et_lat)-1.
  assign err_unit = ~({WIDTH{1'b1}} << et_lat_reg);
  assign err_prod = PRD_W'(beats_next) * PRD_W'(LANES) * PRD_W'(err_unit);
  assign err_next = (err_prod > PRD_W'(ACC_MAX)) ? ACC_MAX : err_prod[ACC_W-1:0];
  assign bus.out_err_bound = out_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg     <= '0;
      out_err_reg <= '0;
    end else begin
      if (clear_frame) begin
        err_reg <= '0;
      end else if (s1_valid_reg) begin
        err_reg <= err_next;
      end
      if (load_out) begin
        out_err_reg <= err_reg;
      end
    end
  end
`endif
endmodule

// File: tb/tb_abs_diff_sad_pipe.sv
// Randomized + directed bench for abs_diff_sad_pipe; two instances (ACC_W 26 and 10)
// share one stimulus stream and are checked against an arithmetic frame model.
module tb_abs_diff_sad_pipe;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int ET_W  = 3;
  localparam int ACC0  = 26;
  localparam int ACC1  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  et = '0;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] fa[$];
  logic [31:0] fb[$];
  int          fe[$];

  logic [63:0] e0_sad, e0_sat, e0_err, e1_sad, e1_sat, e1_err, e_beats;

  always #5 clk = ~clk;

  abs_diff_sad_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC0), .CNT_W(CNT_W), .ET_W(ET_W)) bus0 ();
  abs_diff_sad_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC1), .CNT_W(CNT_W), .ET_W(ET_W)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus0.in_last   = in_last;
  assign bus0.et        = et;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.in_last   = in_last;
  assign bus1.et        = et;
  assign bus1.out_ready = out_ready;

  abs_diff_sad_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC0), .CNT_W(CNT_W), .ET_W(ET_W)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  abs_diff_sad_pipe #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC1), .CNT_W(CNT_W), .ET_W(ET_W)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Frame result from plain arithmetic: truncate each |a-b| to a multiple of 2^et.
  task automatic model(input int acc_w, output logic [63:0] sad, output logic [63:0] sat,
                       output logic [63:0] err, output logic [63:0] beats);
    longint total, mx, eb;
    int e, n;
    total = 0;
    n = fa.size();
    e = (fe[0] > WIDTH - 1) ? WIDTH - 1 : fe[0];
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < LANES; i++) begin
        logic [31:0] wa, wb;
        int av, bv, d;
        wa = fa[k];
        wb = fb[k];
        av = int'(wa[i*8 +: 8]);
        bv = int'(wb[i*8 +: 8]);
        d  = (av > bv) ? av - bv : bv - av;
        total += d - (d % (1 << e));
      end
    end
    mx    = (longint'(1) << acc_w) - 1;
    sad   = (total > mx) ? mx : total;
    sat   = 64'(total > mx);
    eb    = longint'(n) * LANES * ((1 << e) - 1);
    err   = (eb > mx) ? mx : eb;
    beats = (n > 65535) ? 64'd65535 : 64'(n);
  endtask

  task automatic check_results(input string tag);
    check_val({tag, "_sad0"},   bus0.out_sad,   e0_sad);
    check_val({tag, "_beats0"}, bus0.out_beats, e_beats);
    check_val({tag, "_sat0"},   bus0.out_sat,   e0_sat);
    check_val({tag, "_sad1"},   bus1.out_sad,   e1_sad);
    check_val({tag, "_beats1"}, bus1.out_beats, e_beats);
    check_val({tag, "_sat1"},   bus1.out_sat,   e1_sat);
`ifdef ABS_DIFF_ERR_BOUND_EN
    check_val({tag, "_err0"},   bus0.out_err_bound, e0_err);
    check_val({tag, "_err1"},   bus1.out_err_bound, e1_err);
`endif
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic last, input int e);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    et       = 3'(e);
    in_valid = 1'b1;
    while (!bus0.in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check_val("ready_timeout", 64'(guard), 64'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int hold, input int gap_max);
    logic [63:0] dummy;
    model(ACC0, e0_sad, e0_sat, e0_err, e_beats);
    model(ACC1, e1_sad, e1_sat, e1_err, dummy);
    for (int k = 0; k < fa.size(); k++) begin
      repeat ($urandom_range(0, gap_max)) step();
      drive_beat(fa[k], fb[k], k == fa.size() - 1, fe[k]);
    end
    check_val("flush_ready", bus0.in_ready, 0);
    check_val("lat_t0_valid", bus0.out_valid, 0);
    step();
    check_val("lat_t1_valid", bus0.out_valid, 0);
    step();
    check_val("lat_t2_valid0", bus0.out_valid, 1);
    check_val("lat_t2_valid1", bus1.out_valid, 1);
    check_results("done");
    for (int h = 0; h < hold; h++) begin
      step();
      check_val("hold_valid", bus0.out_valid, 1);
      check_val("hold_ready", bus0.in_ready, 0);
      check_results("hold");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("post_valid", bus0.out_valid, 0);
    check_val("post_ready", bus0.in_ready, 1);
    check_results("post");
    $display("frame beats=%0d et=%0d sad0=%0d sad1=%0d sat1=%0d", e_beats, fe[0], e0_sad, e1_sad, e1_sat);
    fa.delete();
    fb.delete();
    fe.delete();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input int e);
    fa.push_back(a);
    fb.push_back(b);
    fe.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_val("rst_valid", bus0.out_valid, 0);
    check_val("rst_ready", bus0.in_ready, 1);
    check_val("rst_sad",   bus0.out_sad, 0);
    check_val("rst_beats", bus0.out_beats, 0);
    check_val("rst_sat",   bus0.out_sat, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // single beat, et 0 then et 2
    push(pack4(10, 200, 0, 255), pack4(20, 100, 0, 0), 0);
    run_frame(0, 0);
    push(pack4(10, 200, 0, 255), pack4(20, 100, 0, 0), 2);
    run_frame(0, 2);

    // 3-beat frame, back-to-back beats, 5 cycles of backpressure
    push(pack4(25, 25, 25, 25), 32'd0, 0);
    push(pack4(50, 50, 50, 50), 32'd0, 0);
    push(pack4(75, 75, 75, 75), 32'd0, 0);
    run_frame(5, 0);

    // saturation on the narrow instance, then a clean follow-up frame
    for (int k = 0; k < 3; k++) push(pack4(255, 255, 255, 255), 32'd0, 0);
    run_frame(1, 0);
    push(pack4(1, 1, 1, 1), 32'd0, 0);
    run_frame(0, 0);

    // asynchronous reset between beats 2 and 3
    for (int k = 0; k < 3; k++) push(pack4(9, 9, 9, 9), 32'd0, 0);
    for (int k = 0; k < 2; k++) drive_beat(fa[k], fb[k], 1'b0, 0);
    check_val("pre_rst_sad", bus0.out_sad, 4);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", bus0.out_valid, 0);
    check_val("arst_sad0",  bus0.out_sad, 0);
    check_val("arst_beats", bus0.out_beats, 0);
    check_val("arst_sad1",  bus1.out_sad, 0);
    step();
    rst = 1'b0;
    step();
    fa.delete();
    fb.delete();
    fe.delete();
    push(pack4(3, 0, 5, 1), pack4(0, 2, 5, 0), 0);
    run_frame(1, 0);

    // et change mid-frame is ignored; next frame uses et=3
    push(pack4(7, 7, 7, 7), 32'd0, 0);
    push(pack4(7, 7, 7, 7), 32'd0, 3);
    run_frame(0, 0);
    push(pack4(7, 7, 7, 7), 32'd0, 3);
    push(pack4(7, 7, 7, 7), 32'd0, 3);
    run_frame(0, 0);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        logic [31:0] a, b;
        a = $urandom();
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
        push(a, b, $urandom_range(0, 7));
      end
      run_frame($urandom_range(0, 3), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
